// File: rtl/vga_timing_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_controller
// Purpose  : 640x480@60 raster sequencer with frame-gated run control and
//            sync/video/marker decode. Define VGA_SYNC_PIPE_EN to register
//            the decoded outputs one cycle behind the counters.
// Revision : 1.0
// ============================================================================
module vga_timing_controller #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33
) (
   input  logic        clk_25MHz,
   input  logic        reset,
   input  logic        run,
   output logic [15:0] H_Count_Value,
   output logic [15:0] V_Count_Value,
   output logic        enable_V_Counter,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start,
   output logic        busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] C_H_LAST     = 16'(H_TOTAL - 1);
   localparam logic [15:0] C_V_LAST     = 16'(V_TOTAL - 1);
   localparam logic [15:0] C_H_VIS      = 16'(H_ACTIVE);
   localparam logic [15:0] C_V_VIS      = 16'(V_ACTIVE);
   localparam logic [15:0] C_H_SYNC_BEG = 16'(H_ACTIVE + H_FRONT);
   localparam logic [15:0] C_H_SYNC_END = 16'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [15:0] C_V_SYNC_BEG = 16'(V_ACTIVE + V_FRONT);
   localparam logic [15:0] C_V_SYNC_END = 16'(V_ACTIVE + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] h_q, h_d;
   logic [15:0] v_q, v_d;

   logic w_advance;
   logic w_busy;
   logic w_h_last;
   logic w_v_last;
   logic w_frame_last;
   logic w_en_v;
   logic w_hsync;
   logic w_vsync;
   logic w_video_on;
   logic w_line_start;
   logic w_frame_start;

   assign w_busy       = (state_q != ST_IDLE);
   assign w_h_last     = (h_q == C_H_LAST);
   assign w_v_last     = (v_q == C_V_LAST);
   assign w_frame_last = w_h_last && w_v_last;

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         h_q     <= '0;
         v_q     <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   // Stopping is only allowed once the counters sit on the last pixel of a
   // frame, so the raster always resumes from (0,0).
   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      v_d       = v_q;
      w_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            h_d = '0;
            v_d = '0;
            if (run) state_d = ST_RUN;
         end
         ST_RUN: begin
            w_advance = 1'b1;
            if (!run) state_d = w_frame_last ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            w_advance = 1'b1;
            if (run)               state_d = ST_RUN;
            else if (w_frame_last) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
         end
      endcase

      if (w_advance) begin
         if (w_h_last) begin
            h_d = '0;
            v_d = w_v_last ? 16'd0 : v_q + 16'd1;
         end else begin
            h_d = h_q + 16'd1;
         end
      end
   end

   assign w_en_v        = w_busy && w_h_last;
   assign w_hsync       = !(w_busy && (h_q >= C_H_SYNC_BEG) && (h_q < C_H_SYNC_END));
   assign w_vsync       = !(w_busy && (v_q >= C_V_SYNC_BEG) && (v_q < C_V_SYNC_END));
   assign w_video_on    = w_busy && (h_q < C_H_VIS) && (v_q < C_V_VIS);
   assign w_line_start  = w_busy && (h_q == 16'd0);
   assign w_frame_start = w_line_start && (v_q == 16'd0);

   assign H_Count_Value = h_q;
   assign V_Count_Value = v_q;
   assign busy          = w_busy;

`ifdef VGA_SYNC_PIPE_EN
   logic en_v_q,        en_v_d;
   logic hsync_q,       hsync_d;
   logic vsync_q,       vsync_d;
   logic video_on_q,    video_on_d;
   logic line_start_q,  line_start_d;
   logic frame_start_q, frame_start_d;

   always_comb begin
      en_v_d        = w_en_v;
      hsync_d       = w_hsync;
      vsync_d       = w_vsync;
      video_on_d    = w_video_on;
      line_start_d  = w_line_start;
      frame_start_d = w_frame_start;
   end

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         en_v_q        <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         en_v_q        <= en_v_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign enable_V_Counter = en_v_q;
   assign hsync            = hsync_q;
   assign vsync            = vsync_q;
   assign video_on         = video_on_q;
   assign line_start       = line_start_q;
   assign frame_start      = frame_start_q;
`else
   assign enable_V_Counter = w_en_v;
   assign hsync            = w_hsync;
   assign vsync            = w_vsync;
   assign video_on         = w_video_on;
   assign line_start       = w_line_start;
   assign frame_start      = w_frame_start;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_controller
// Purpose  : Scoreboard bench for vga_timing_controller on a reduced raster
//            (30x17 total) so whole frames, stops and restarts fit in a short run.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_controller;

   localparam int HA = 16, HF = 4, HS = 6, HB = 4;
   localparam int VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;   // 30
   localparam int VT = VA + VF + VS + VB;   // 17
   localparam int FRAME = HT * VT;          // 510
`ifdef VGA_SYNC_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] H_Count_Value;
   logic [15:0] V_Count_Value;
   logic        enable_V_Counter;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic        line_start;
   logic        frame_start;
   logic        busy;

   always #5 clk = ~clk;

   vga_timing_controller #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk_25MHz        (clk),
      .reset            (reset),
      .run              (run),
      .H_Count_Value    (H_Count_Value),
      .V_Count_Value    (V_Count_Value),
      .enable_V_Counter (enable_V_Counter),
      .hsync            (hsync),
      .vsync            (vsync),
      .video_on         (video_on),
      .line_start       (line_start),
      .frame_start      (frame_start),
      .busy             (busy)
   );

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        en;
      logic        hs;
      logic        vs;
      logic        vid;
      logic        ls;
      logic        fs;
      logic        busy;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for a raster position p = v*HT + h
   function automatic exp_t decode(input int st, input int p);
      exp_t e;
      int   h;
      int   v;
      logic b;
      h = p % HT;
      v = p / HT;
      b = (st != 0);
      e.h    = 16'(h);
      e.v    = 16'(v);
      e.busy = b;
      e.en   = b && (h == HT - 1);
      e.hs   = !(b && (h >= HA + HF) && (h < HA + HF + HS));
      e.vs   = !(b && (v >= VA + VF) && (v < VA + VF + VS));
      e.vid  = b && (h < HA) && (v < VA);
      e.ls   = b && (h == 0);
      e.fs   = b && (p == 0);
      return e;
   endfunction

   // Model: 0 = idle, 1 = run, 2 = drain
   int   m_state;
   int   m_p;
   exp_t m_cur;
   exp_t m_pipe;

   task automatic step(input logic r);
      exp_t e;
      bit   last;
      run = r;
      @(posedge clk);
      if (reset) begin
         m_state = 0;
         m_p     = 0;
         m_pipe  = decode(0, 0);
      end else begin
         m_pipe = m_cur;
         last   = (m_p == FRAME - 1);
         case (m_state)
            0: begin
               m_p = 0;
               if (r) m_state = 1;
            end
            1: begin
               m_p = (m_p + 1) % FRAME;
               if (!r) m_state = last ? 0 : 2;
            end
            default: begin
               m_p = (m_p + 1) % FRAME;
               if (r)         m_state = 1;
               else if (last) m_state = 0;
            end
         endcase
      end
      m_cur = decode(m_state, m_p);
      e = m_cur;
      if (PIPE != 0) begin
         e.en  = m_pipe.en;
         e.hs  = m_pipe.hs;
         e.vs  = m_pipe.vs;
         e.vid = m_pipe.vid;
         e.ls  = m_pipe.ls;
         e.fs  = m_pipe.fs;
      end
      #1;
      q.push_back(e);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("h_count",     H_Count_Value,         e.h);
         chk("v_count",     V_Count_Value,         e.v);
         chk("enable_v",    16'(enable_V_Counter), 16'(e.en));
         chk("hsync",       16'(hsync),            16'(e.hs));
         chk("vsync",       16'(vsync),            16'(e.vs));
         chk("video_on",    16'(video_on),         16'(e.vid));
         chk("line_start",  16'(line_start),       16'(e.ls));
         chk("frame_start", 16'(frame_start),      16'(e.fs));
         chk("busy",        16'(busy),             16'(e.busy));
      end
   end

   // Raster-shape monitor with hand-derived constants
   int cyc = 0;
   int hs_len = 0;
   int vs_len = 0;
   int vid_cnt = 0;
   int fs_cyc = 0;
   bit fs_valid = 1'b0;
   bit hs_p = 1'b1;
   bit vs_p = 1'b1;

   always @(negedge clk) begin
      cyc++;
      if (reset || !busy) begin
         fs_valid = 1'b0;
         hs_len   = 0;
         vs_len   = 0;
         hs_p     = 1'b1;
         vs_p     = 1'b1;
      end else begin
         if (frame_start) begin
            if (fs_valid) begin
               chk("frame_period", 16'(cyc - fs_cyc), 16'(FRAME));
               chk("video_cycles", 16'(vid_cnt),      16'(HA * VA));
            end
            fs_valid = 1'b1;
            fs_cyc   = cyc;
            vid_cnt  = 0;
         end
         if (video_on) vid_cnt++;
         if (!hsync) hs_len++;
         if (!vsync) vs_len++;
         if (hs_p && !hsync) chk("hsync_fall_h", H_Count_Value, 16'(HA + HF + PIPE));
         if (!hs_p && hsync) begin
            chk("hsync_width", 16'(hs_len), 16'(HS));
            hs_len = 0;
         end
         if (vs_p && !vsync) begin
            chk("vsync_fall_v", V_Count_Value, 16'(VA + VF));
            chk("vsync_fall_h", H_Count_Value, 16'(PIPE));
         end
         if (!vs_p && vsync) begin
            chk("vsync_width", 16'(vs_len), 16'(VS * HT));
            vs_len = 0;
         end
         hs_p = hsync;
         vs_p = vsync;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (m_p != target && guard < 2 * FRAME) begin
         step(1'b1);
         guard++;
      end
      chk("reach_position", 16'(m_p), 16'(target));
   endtask

   initial begin
      int guard;
      reset   = 1'b1;
      run     = 1'b0;
      m_state = 0;
      m_p     = 0;
      m_cur   = decode(0, 0);
      m_pipe  = m_cur;

      repeat (3) step(1'b0);
      reset = 1'b0;
      repeat (2) step(1'b0);

      // Two full frames plus a partial one
      for (int i = 0; i < 2 * FRAME + 40; i++) step(1'b1);

      // Drop run mid-frame: frame must complete before IDLE
      run_to(3 * HT);
      guard = 0;
      while (m_state != 0 && guard < FRAME + 5) begin
         step(1'b0);
         guard++;
      end
      repeat (3) step(1'b0);
      chk("idle_busy",  16'(busy),     16'd0);
      chk("idle_h",     H_Count_Value, 16'd0);
      chk("idle_v",     V_Count_Value, 16'd0);

      // Restart, then request a stop and re-raise run while draining
      run_to(8 * HT);
      repeat (35) step(1'b0);
      chk("drain_busy", 16'(busy), 16'd1);
      for (int i = 0; i < FRAME + 20; i++) step(1'b1);

      // Asynchronous reset between edges at (H=10, V=5)
      run_to(5 * HT + 10);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_h",           H_Count_Value,         16'd0);
      chk("arst_v",           V_Count_Value,         16'd0);
      chk("arst_hsync",       16'(hsync),            16'd1);
      chk("arst_vsync",       16'(vsync),            16'd1);
      chk("arst_video_on",    16'(video_on),         16'd0);
      chk("arst_enable_v",    16'(enable_V_Counter), 16'd0);
      chk("arst_line_start",  16'(line_start),       16'd0);
      chk("arst_frame_start", 16'(frame_start),      16'd0);
      chk("arst_busy",        16'(busy),             16'd0);
      m_state = 0;
      m_p     = 0;
      m_cur   = decode(0, 0);
      m_pipe  = m_cur;
      step(1'b1);
      reset = 1'b0;
      for (int i = 0; i < FRAME + 40; i++) step(1'b1);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_controller.md
# vga_timing_controller

- Sequences the 640x480@60 Hz raster for the 25 MHz pixel clock domain.
- Owns the horizontal pixel counter and the line-advance strobe that drives the vertical counter's enable; decodes both into active-low sync pulses, a video-active flag and line/frame markers.
- Gates the raster on and off cleanly at frame boundaries: starts only at pixel (0,0) and stops only after a complete frame.
- Sits between the top-level run control and the pixel generator / VGA output pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk_25MHz  input  1  pixel clock, single clock domain
- reset  input  1  asynchronous, active-high
- run  input  1  level request: 1 = raster running, 0 = stop at end of frame
- H_Count_Value  output  16  horizontal position, 0..H_TOTAL-1 (H_TOTAL = sum of H_*, default 800)
- V_Count_Value  output  16  vertical position, 0..V_TOTAL-1 (V_TOTAL default 525)
- enable_V_Counter  output  1  one-cycle line-advance strobe
- hsync, vsync  output  1 each  active-low sync pulses
- video_on  output  1  high when H < H_ACTIVE and V < V_ACTIVE
- line_start, frame_start  output  1 each  one-cycle markers
- busy  output  1  high while the state machine is not IDLE

## Operation
- State machine: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0, all strobes low; run=1 moves to RUN on the next edge.
  - RUN: counters advance every cycle; run=0 moves to DRAIN.
  - DRAIN: counters keep advancing until wrap to (0,0), then go to IDLE. run=1 during DRAIN returns to RUN with no disturbance to the counters.
- Horizontal counter: increments each RUN/DRAIN cycle; at H_TOTAL-1 wraps to 0.
- enable_V_Counter: high exactly in cycles where H = H_TOTAL-1.
- Vertical counter: advances on that strobe; at V_TOTAL-1 wraps to 0.
- Both counters are 16-bit unsigned; compare with `>=`/`<` against parameter sums, no overflow possible at defaults.
- Sync windows:
  - hsync low for H_ACTIVE+H_FRONT <= H < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync low for V_ACTIVE+V_FRONT <= V < V_ACTIVE+V_FRONT+V_SYNC (490..491).
- Markers:
  - line_start = busy and H==0.
  - frame_start = busy and H==0 and V==0.
- In IDLE: hsync=vsync=1, video_on=0, all strobes 0.

## Timing
- Reset value of every output: counters 0, hsync=vsync=1, video_on=0, enable_V_Counter=line_start=frame_start=0, busy=0. State is IDLE.
- Reset mid-frame: reset takes effect immediately (asynchronous); all outputs return to reset values in the same cycle.
- Start: run sampled high at edge N. State is RUN after edge N. First frame_start is the cycle after edge N, with H=V=0. The first increment occurs at edge N+1.
- Decode is combinational from counters: sync/video_on align with the counter value of the same cycle. Zero latency without the macro.
- Frame length is exactly 800×525 = 420000 cycles; line length is 800 cycles.
- Stop: after the last DRAIN cycle (H=799, V=524), the next edge gives IDLE with counters at 0.

## Configuration
- VGA_SYNC_PIPE_EN defined:
  - hsync, vsync, video_on, line_start, frame_start and enable_V_Counter are registered: one cycle later than the counters' same-cycle decode.
  - Counters are unchanged.
  - These registered outputs also take their reset values asynchronously.
- Undefined: all decodes are combinational, zero latency.

## Test plan
- Reset then run=1: frame_start pulses once at H=0,V=0. The next frame_start comes 420000 cycles later.
- Line boundary: at H=799, enable_V_Counter=1 for one cycle; next cycle H=0, V incremented by 1. At V=524, H=799, V wraps to 0.
- Sync windows: hsync low for exactly 96 cycles starting at H=656. vsync low for exactly 1600 cycles starting at V=490, H=0. video_on high for 640×480 = 307200 cycles per frame.
- Stop/restart: drop run at V=100; frame completes to H=799,V=524, then IDLE with busy=0. Raise run during DRAIN at V=300: no counter discontinuity, busy stays 1.
- Async reset mid-frame (V=250, H=400), asserted between clock edges: all outputs reach reset values before the next edge. Reset then released with run=1: restart from (0,0).
- VGA_SYNC_PIPE_EN defined: repeat the sync-window test; hsync falls at the cycle where H=657.
